// File: rtl/cbr_out_collector_pkg.sv
// Purpose: shared constants and entry type for the CBR output collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cbr_out_collector_pkg;
    localparam int ROW_NUM_IN_SA = 16;
    localparam int DATA_W        = 8;
    localparam int LANES         = 16;
    localparam int ROW_IDX_W     = 6;

    // One buffered result vector together with its output channel index.
    typedef struct packed {
        logic [ROW_IDX_W-1:0]    row_idx;
        logic [LANES*DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/cbr_sync_fifo.sv
// Purpose: generic register-array FIFO with occupancy count and pointer wrap.
// Latency: a push becomes visible at the head on the next cycle (no bypass).
// Backpressure: a push while full is refused unless a pop happens in the same cycle.
module cbr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     push_acc,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign push_acc = push && (!full || pop_ok);
    assign pop_ok   = pop && (count_q != '0);
    assign dout     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;

    // Next-state: write slot, pointer advance (natural wrap, DEPTH is 2^n) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_acc && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_acc && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        if (reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State registers; storage itself is not reset, only the pointers.
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end
endmodule

// File: rtl/cbr_out_collector.sv
// Purpose: buffer relu/scale result vectors, tag group ends, write them to the output map.
// Latency: 1 cycle from conv_fifo_en to wr_valid; group_done 1 cycle after the last beat pops.
// Backpressure: head holds while wr_ready=0; pushes into a full FIFO are dropped (overflow).
module cbr_out_collector #(
    parameter int DATA_W = cbr_out_collector_pkg::DATA_W,
    parameter int LANES  = cbr_out_collector_pkg::LANES,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         base_addr_init,
    input  logic [ADDR_W-1:0]         ch_stride_init,
    input  logic                      conv_fifo_en,
    input  logic                      conv_fifo_add_end,
    input  logic [5:0]                out_sa_row_idx,
    input  logic [LANES*DATA_W-1:0]   din,
    input  logic                      wr_ready,
    output logic                      wr_valid,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      wr_last,
    output logic                      group_done,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    output logic                      idx_err
);
    import cbr_out_collector_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DW    = LANES * DATA_W;
    localparam int EW    = ROW_IDX_W + DW;

    logic              push_acc, pop, full, head_vld, mark_hit, mark_en;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, last_ptr;
    logic [PTR_W:0]    count;
    logic [EW-1:0]     head;
    logic [ROW_IDX_W-1:0] head_row;
    logic [DW-1:0]     head_data;
    logic [ADDR_W-1:0] head_addr;

    logic [ADDR_W-1:0] base_addr_q, base_addr_d, ch_stride_q, ch_stride_d;
    logic [ADDR_W-1:0] pixel_ofs_q, pixel_ofs_d;
    logic [DEPTH-1:0]  last_bit_q, last_bit_d;
    logic              overflow_q, overflow_d, idx_err_q, idx_err_d;
    logic              group_done_q, group_done_d;

    cbr_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (conv_fifo_en),
        .pop      (pop),
        .din      ({out_sa_row_idx, din}),
        .dout     (head),
        .push_acc (push_acc),
        .full     (full),
        .count    (count),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr)
    );

    assign {head_row, head_data} = head;
    assign last_ptr  = wr_ptr - PTR_W'(1);
    assign head_vld  = !reset && (count != '0);
    // add_end arriving while the just-pushed entry sits at the head still marks it.
    assign mark_hit  = conv_fifo_add_end && (rd_ptr == last_ptr);
    assign head_addr = base_addr_q
                     + (ADDR_W'(head_row) - ADDR_W'(1)) * ch_stride_q
                     + pixel_ofs_q;

    assign pop        = head_vld && wr_ready;
    assign wr_valid   = head_vld;
    assign wr_addr    = head_vld ? head_addr : '0;
    assign wr_data    = head_vld ? head_data : '0;
    assign wr_last    = head_vld && (last_bit_q[rd_ptr] || mark_hit);
    assign group_done = group_done_q;
    assign fifo_count = count;
    assign overflow   = overflow_q;
    assign idx_err    = idx_err_q;

    // Skip the mark when its target is the head leaving this cycle; the bypass covered it.
    assign mark_en = conv_fifo_add_end && (count != '0) && !(pop && (rd_ptr == last_ptr));

    // Next-state for last marks, pixel offset, sticky flags and latched geometry.
    always_comb begin
        base_addr_d  = base_addr_q;
        ch_stride_d  = ch_stride_q;
        pixel_ofs_d  = pixel_ofs_q;
        last_bit_d   = last_bit_q;
        overflow_d   = overflow_q;
        idx_err_d    = idx_err_q;
        group_done_d = pop && wr_last;
        if (mark_en) begin
            last_bit_d[last_ptr] = 1'b1;
        end
        if (push_acc) begin
            last_bit_d[wr_ptr] = 1'b0;
            if (out_sa_row_idx == 6'd0) begin
                idx_err_d = 1'b1;
            end
        end
        if (conv_fifo_en && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (pop && wr_last) begin
            pixel_ofs_d = pixel_ofs_q + ADDR_W'(1);
        end
        if (reset) begin
            base_addr_d  = base_addr_init;
            ch_stride_d  = ch_stride_init;
            pixel_ofs_d  = '0;
            last_bit_d   = '0;
            overflow_d   = 1'b0;
            idx_err_d    = 1'b0;
            group_done_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        base_addr_q  <= base_addr_d;
        ch_stride_q  <= ch_stride_d;
        pixel_ofs_q  <= pixel_ofs_d;
        last_bit_q   <= last_bit_d;
        overflow_q   <= overflow_d;
        idx_err_q    <= idx_err_d;
        group_done_q <= group_done_d;
    end
endmodule

// File: tb/tb_cbr_out_collector.sv
// Purpose: self-checking bench for cbr_out_collector against a queue-based model.
// Latency: model predicts outputs combinationally each cycle.
// Backpressure: wr_ready driven directly by the stimulus.
module tb_cbr_out_collector;
    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  base_init, stride_init;
    logic         en, add_end;
    logic [5:0]   row;
    logic [127:0] din;
    logic         wr_ready;
    logic         wr_valid, wr_last, group_done, overflow, idx_err;
    logic [15:0]  wr_addr;
    logic [127:0] wr_data;
    logic [5:0]   fifo_count;

    cbr_out_collector dut (
        .clk(clk), .reset(reset), .base_addr_init(base_init), .ch_stride_init(stride_init),
        .conv_fifo_en(en), .conv_fifo_add_end(add_end), .out_sa_row_idx(row), .din(din),
        .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_last(wr_last), .group_done(group_done), .fifo_count(fifo_count),
        .overflow(overflow), .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]   row;
        logic [127:0] data;
        bit           last;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_base, m_stride, m_pix;
    bit          m_ovf, m_idx, m_gd;
    bit          cmp_en = 0;

    int           gd_cnt = 0;
    logic [15:0]  log_addr[$];
    bit           log_last[$];
    logic [127:0] log_data[$];

    function automatic bit m_valid();
        return !reset && (mq.size() != 0);
    endfunction

    // Head is last if marked, or if add_end arrives while it is the only (newest) entry.
    function automatic bit m_last();
        if (!m_valid()) return 1'b0;
        return mq[0].last || (add_end && mq.size() == 1);
    endfunction

    function automatic logic [15:0] m_addr();
        logic [15:0] r;
        r = 16'(mq[0].row) - 16'd1;
        return m_base + r * m_stride + m_pix;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: advance the queue on each clock edge.
    always @(posedge clk) begin
        bit pop_m, plast, full_m;
        if (reset) begin
            mq.delete();
            m_base = base_init; m_stride = stride_init; m_pix = '0;
            m_ovf = 0; m_idx = 0; m_gd = 0;
            cmp_en = 1;
        end else if (cmp_en) begin
            pop_m  = m_valid() && wr_ready;
            plast  = m_last();
            full_m = (mq.size() == 32);
            if (add_end) begin
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL add_end_lost actual=empty required=nonempty");
                end else if (!(pop_m && mq.size() == 1)) begin
                    mq[mq.size()-1].last = 1'b1;
                end
            end
            if (pop_m) void'(mq.pop_front());
            if (en) begin
                if (!full_m || pop_m) begin
                    mq.push_back('{row, din, 1'b0});
                    if (row == 6'd0) m_idx = 1;
                end else begin
                    m_ovf = 1;
                end
            end
            m_gd = pop_m && plast;
            if (pop_m && plast) m_pix = m_pix + 16'd1;
        end
    end

    logic         pv = 0, pr = 0, prst = 1;
    logic [15:0]  pa;
    logic [127:0] pd;

    // Compare process: DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wr_valid", wr_valid, m_valid());
            if (m_valid()) begin
                chk("wr_data", wr_data, mq[0].data);
                chk("wr_addr", wr_addr, m_addr());
                chk("wr_last", wr_last, m_last());
            end
            if (reset) begin
                chk("rst_addr", wr_addr, 0);
                chk("rst_data", wr_data, 0);
                chk("rst_last", wr_last, 0);
            end
            chk("fifo_count", fifo_count, mq.size());
            chk("overflow", overflow, m_ovf);
            chk("idx_err", idx_err, m_idx);
            chk("group_done", group_done, m_gd);
            if (pv && !pr && !prst && !reset) begin
                chk("stall_addr", wr_addr, pa);
                chk("stall_data", wr_data, pd);
            end
            if (wr_valid && wr_ready) begin
                log_addr.push_back(wr_addr);
                log_last.push_back(wr_last);
                log_data.push_back(wr_data);
            end
            if (group_done) gd_cnt++;
            pv = wr_valid; pr = wr_ready; prst = reset; pa = wr_addr; pd = wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_beat(input logic [5:0] r, input logic [127:0] d);
        en = 1; row = r; din = d;
        tick();
        en = 0;
    endtask

    task automatic do_reset(input logic [15:0] b, input logic [15:0] s);
        base_init = b; stride_init = s; reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (fifo_count != 0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", fifo_count);
        end
        tick(); tick();
    endtask

    task automatic clear_log();
        log_addr.delete(); log_last.delete(); log_data.delete(); gd_cnt = 0;
    endtask

    initial begin
        logic [127:0] exp_d[$];
        logic [15:0]  exp_a[5];
        bit           exp_l[5];
        bit           last_en;
        en = 0; add_end = 0; row = 0; din = 0; wr_ready = 1;

        // Basic group plus single-beat bypass group.
        do_reset(16'h0100, 16'h0040);
        clear_log();
        for (int i = 4; i >= 1; i--) push_beat(6'(i), rnd128());
        add_end = 1;
        @(negedge clk);
        chk("t1_bypass_last", wr_last, 1);
        tick();
        add_end = 0;
        @(negedge clk);
        chk("t1_group_done", group_done, 1);
        tick(); tick();
        push_beat(6'd1, rnd128());
        add_end = 1;
        @(negedge clk);
        chk("t3_bypass_last", wr_last, 1);
        tick();
        add_end = 0;
        @(negedge clk);
        chk("t3_group_done", group_done, 1);
        tick(); tick();
        exp_a = '{16'h01C0, 16'h0180, 16'h0140, 16'h0100, 16'h0101};
        exp_l = '{0, 0, 0, 1, 1};
        chk("t1_nwrites", log_addr.size(), 5);
        for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
            chk("t1_addr", log_addr[i], exp_a[i]);
            chk("t1_last", log_last[i], exp_l[i]);
        end
        chk("t1_gd_cnt", gd_cnt, 2);

        // Fill to full, drop one, drain in order.
        clear_log();
        wr_ready = 0;
        for (int i = 0; i < 33; i++) begin
            logic [127:0] d = rnd128();
            if (i < 32) exp_d.push_back(d);
            push_beat(6'($urandom_range(1, 16)), d);
        end
        @(negedge clk);
        chk("t2_count", fifo_count, 32);
        chk("t2_overflow", overflow, 1);
        tick();
        add_end = 1;
        tick();
        add_end = 0;
        wr_ready = 1;
        wait_drain();
        chk("t2_nwrites", log_data.size(), 32);
        for (int i = 0; i < 32 && i < log_data.size(); i++) chk("t2_order", log_data[i], exp_d[i]);

        // Two 16-beat groups, overlapping add_end/push, ready toggling 1010.
        do_reset(16'h0300, 16'h0020);
        clear_log();
        fork
            begin
                for (int i = 16; i >= 1; i--) push_beat(6'(i), rnd128());
                add_end = 1;
                push_beat(6'd16, rnd128());
                add_end = 0;
                for (int i = 15; i >= 1; i--) push_beat(6'(i), rnd128());
                add_end = 1;
                tick();
                add_end = 0;
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    wr_ready = (k % 2 == 0);
                    tick();
                end
            end
        join
        wr_ready = 1;
        wait_drain();
        chk("t4_nwrites", log_data.size(), 32);
        chk("t4_gd_cnt", gd_cnt, 2);
        wr_ready = 0;
        push_beat(6'd1, rnd128());
        @(negedge clk);
        chk("t4_pixel_ofs", wr_addr, 16'h0302);
        tick();
        wr_ready = 1;
        wait_drain();

        // Row index 0 wraps the channel term and sets the sticky flag.
        do_reset(16'h0100, 16'h0040);
        wr_ready = 0;
        push_beat(6'd0, rnd128());
        @(negedge clk);
        chk("t5_addr", wr_addr, 16'h00C0);
        chk("t5_idx_err", idx_err, 1);
        tick();
        wr_ready = 1;
        wait_drain();
        chk("t5_idx_sticky", idx_err, 1);

        // Reset with entries buffered discards them and latches new geometry.
        wr_ready = 0;
        for (int i = 0; i < 10; i++) push_beat(6'($urandom_range(1, 16)), rnd128());
        @(negedge clk);
        chk("t6_count10", fifo_count, 10);
        tick();
        do_reset(16'h2000, 16'h0010);
        @(negedge clk);
        chk("t6_valid", wr_valid, 0);
        chk("t6_count", fifo_count, 0);
        chk("t6_idx_err", idx_err, 0);
        tick();
        push_beat(6'd2, rnd128());
        @(negedge clk);
        chk("t6_addr", wr_addr, 16'h2010);
        tick();
        wr_ready = 1;
        wait_drain();

        // Randomized traffic with stall bursts, row 0, overflow and group marks.
        do_reset(16'($urandom()), 16'($urandom()));
        last_en = 0;
        for (int k = 0; k < 900; k++) begin
            en       = ($urandom_range(0, 2) != 0);
            row      = 6'($urandom_range(0, 16));
            din      = rnd128();
            wr_ready = ((k / 50) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            add_end  = last_en && (mq.size() > 0) && ($urandom_range(0, 3) == 0);
            last_en  = en;
            tick();
        end
        en = 0; add_end = 0; wr_ready = 1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cbr_out_collector.md
Name: cbr_out_collector

Overview:
Downstream neighbour of the CBR kernel controller. It captures the per-output-channel quantized results that the relu/scale stage emits while conv_fifo_en is high, and buffers them in a small FIFO. It tags group boundaries from the conv_fifo_add_end pulse and drains entries to the output feature-map buffer over a valid/ready write port. The write address is computed from the systolic-array row index.

Parameters:
DATA_W, 8, bits per output pixel lane
LANES, 16, lanes per FIFO entry (one sa row result vector)
DEPTH, 32, FIFO entries (power of 2)
ADDR_W, 16, output buffer word-address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
base_addr_init  in  ADDR_W  output tile base address, latched while reset=1
ch_stride_init  in  ADDR_W  address distance between output channels, latched while reset=1
conv_fifo_en  in  1  push strobe: din/out_sa_row_idx valid this cycle
conv_fifo_add_end  in  1  1-cycle pulse in the cycle after the final push of a group
out_sa_row_idx  in  6  output channel index of this beat, legal range 1..16 (counts down)
din  in  LANES*DATA_W  result vector
wr_ready  in  1  output buffer accepts a write
wr_valid  out  1  write request
wr_addr  out  ADDR_W  write address
wr_data  out  LANES*DATA_W  write data
wr_last  out  1  current beat is the last of a group
group_done  out  1  1-cycle pulse after the last beat of a group is accepted
fifo_count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: a push was dropped
idx_err  out  1  sticky: a push had out_sa_row_idx==0

Behaviour:
- Reset, while reset=1:
  - base_addr and ch_stride latch the *_init inputs.
  - Pointers, fifo_count, pixel_ofs, overflow, idx_err and group_done all clear to 0.
  - wr_valid=0; wr_addr, wr_data and wr_last read as 0.
- Otherwise base_addr and ch_stride hold their values. Reset mid-group discards all buffered entries and pending last marks.
- Entry storage: {row_idx[5:0], data}, held in a register array, plus a separate last_bit array.
- Push rule:
  - A push occurs when conv_fifo_en=1 and (count<DEPTH or pop in the same cycle).
  - The entry is written at wr_ptr and its last_bit is cleared; wr_ptr wraps modulo DEPTH.
  - If conv_fifo_en=1 while full with no pop, the data is dropped and overflow is set.
- Pop rule: a pop occurs when wr_valid && wr_ready. rd_ptr increments and wraps modulo DEPTH.
- Simultaneous push and pop leaves count unchanged. Push into an empty FIFO makes wr_valid=1 the next cycle (latency 1); there is no same-cycle bypass of din.
- Head outputs are read combinationally from rd_ptr:
  - wr_valid = (count != 0).
  - wr_data = data[rd_ptr].
  - wr_addr = base_addr + (row_idx[rd_ptr]-1)*ch_stride + pixel_ofs, truncated to ADDR_W.
- Last marking: conv_fifo_add_end=1 sets last_bit[wr_ptr-1] (the most recent push).
  - Bypass: wr_last = last_bit[rd_ptr] | (conv_fifo_add_end && rd_ptr==wr_ptr-1 && count!=0), so a head entry popped in the same cycle it is marked still reports last.
  - add_end with an empty FIFO, or with the last entry already popped, is ignored. The group still completes, but group_done never fires for it; the verification bench flags this case.
- When a beat with wr_last=1 is popped:
  - pixel_ofs increments by 1 (wraps at 2^ADDR_W).
  - group_done pulses high for exactly 1 cycle on the next clock.
- A row_idx of 0 is still pushed; its address uses (0-1) mod 2^ADDR_W. idx_err sets on the push.
- Back-to-back groups are legal: the push of group N+1 may coincide with the add_end of group N. The mark targets wr_ptr-1 as evaluated before the new push.
- wr_valid, wr_addr, wr_data and wr_last stay stable while wr_valid=1 and wr_ready=0.

Decomposition:
- A shared package holds the CBR output constants: ROW_NUM_IN_SA=16, DATA_W, LANES, and an entry struct type {row_idx, data}.
- One sub-module is natural: cbr_sync_fifo, a generic register-array FIFO with count, full/empty and wrap logic.
- cbr_out_collector itself owns the last_bit array, the bypass, address generation, pixel_ofs and the sticky flags.

Test Plan:
- Reset with base_addr_init=0x100, ch_stride_init=0x40, wr_ready=1. Push 4 beats with idx 4,3,2,1, then add_end.
  -> Writes to 0x1C0, 0x180, 0x140, 0x100 in order; wr_last only on the 0x100 beat; group_done 1 cycle after it; next group starts at pixel_ofs=1 (0x101 for idx 1).
- wr_ready=0 with 32 pushes, then 1 extra push.
  -> fifo_count=32; overflow=1; the 33rd beat is dropped. With wr_ready=1, exactly 32 beats drain in push order.
- Single push of idx 1 with wr_ready=1, add_end the next cycle.
  -> The beat pops in the add_end cycle with wr_last=1 via the bypass; group_done is asserted the following cycle.
- wr_ready toggling 1010… during 16-beat groups with back-to-back add_end/push overlap.
  -> No loss or duplication; exactly 2 group_done pulses; pixel_ofs=2 at the end; outputs stable while stalled.
- Push idx 0.
  -> idx_err=1 stays set; wr_addr = base - ch_stride mod 2^16.
- Assert reset with 10 entries buffered.
  -> Next cycle wr_valid=0, fifo_count=0, flags cleared, new base/stride latched.
